// File: rtl/perf_cntr_bank.sv
// perf_cntr_bank
//   Memory-mapped performance counter bank on the dbus perf window. It replaces
//   the old single mcycle counter. Channel 0 counts clock cycles. Channels
//   1..NUM_CNTRS-1 count single-cycle event pulses from the core. Each channel
//   has a mode (CLEAR / RUN / HOLD), a sticky overflow flag, and a presettable
//   value.
//
//   Optional feature: define PERF_SNAPSHOT_EN to add shadow registers.
//     - A write to SNAP copies every counter into its shadow register in one edge.
//     - Counter reads then return the shadow values.
//     - Without the macro there are no shadow registers, counter reads return
//       the live values, and SNAP writes are ignored.
//
// Register map (byte offsets, addr_i[1:0] ignored):
//   0x00        CTRL    2 bits of mode per counter: 0 CLEAR, 1 RUN, 2/3 HOLD
//   0x04        STATUS  sticky overflow flags, write-1-to-clear
//   0x08        SNAP    write triggers snapshot, reads 0
//   0x40 + 8k   counter k high word (zero-extended)
//   0x44 + 8k   counter k low word
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   we_i        write strobe
//   addr_i      byte address
//   wdata_i     write data
//   event_i     event pulses; bit k feeds counter k (bit 0 unused)
//   rdata_o     registered read data of the address presented in the previous cycle
//   overflow_o  sticky overflow flags, same as STATUS

module perf_cntr_bank #(
  parameter int NUM_CNTRS  = 4,
  parameter int CNTR_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [NUM_CNTRS-1:0]  event_i,
  output logic [31:0]           rdata_o,
  output logic [NUM_CNTRS-1:0]  overflow_o
);

  localparam int         HI_W       = CNTR_WIDTH - 32;
  localparam logic [1:0] MODE_CLEAR = 2'd0;
  localparam logic [1:0] MODE_RUN   = 2'd1;

  // Word-aligned byte address, widened to 32 bits so it compares against
  // plain offsets.
  logic [31:0] addr_word;
  assign addr_word = 32'(addr_i) & 32'hFFFF_FFFC;

  logic ctrl_wr, status_wr, snap_wr;
  assign ctrl_wr   = we_i && (addr_word == 32'h00);
  assign status_wr = we_i && (addr_word == 32'h04);
  assign snap_wr   = we_i && (addr_word == 32'h08);

  logic [1:0]            mode_q [NUM_CNTRS];
  logic [CNTR_WIDTH-1:0] view_q [NUM_CNTRS];  // value that a counter read returns
  logic [NUM_CNTRS-1:0]  ovf_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNTRS; gi++) begin : g_ch
      localparam logic [31:0] HI_OFF = 32'h40 + 32'(8 * gi);

      logic [1:0]            mode_reg, mode_next;
      logic [CNTR_WIDTH-1:0] cnt_reg, cnt_next;
      logic                  ovf_reg, ovf_next;
      logic                  hi_hit, lo_hit, inc, wrap;

      assign hi_hit = we_i && (addr_word == HI_OFF);
      assign lo_hit = we_i && (addr_word == HI_OFF + 32'd4);

      if (gi == 0) begin : g_cyc
        assign inc = (mode_reg == MODE_RUN);
      end else begin : g_evt
        assign inc = (mode_reg == MODE_RUN) && event_i[gi];
      end

      // A preset takes priority over counting. As a result, a preset cycle
      // never wraps the counter and never sets the overflow flag.
      assign wrap = inc && !hi_hit && !lo_hit && (&cnt_reg);

      always_comb begin
        mode_next = mode_reg;
        if (ctrl_wr) begin
          mode_next = wdata_i[2*gi +: 2];
        end

        cnt_next = cnt_reg;
        if (hi_hit) begin
          cnt_next[CNTR_WIDTH-1:32] = wdata_i[HI_W-1:0];
        end else if (lo_hit) begin
          cnt_next[31:0] = wdata_i;
        end else if (mode_reg == MODE_CLEAR) begin
          cnt_next = '0;
        end else if (inc) begin
          cnt_next = cnt_reg + CNTR_WIDTH'(1);
        end

        // A wrap in the same cycle as a W1C leaves the flag set.
        ovf_next = (ovf_reg & ~(status_wr & wdata_i[gi])) | wrap;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          mode_reg <= MODE_CLEAR;
          cnt_reg  <= '0;
          ovf_reg  <= 1'b0;
        end else begin
          mode_reg <= mode_next;
          cnt_reg  <= cnt_next;
          ovf_reg  <= ovf_next;
        end
      end

      assign mode_q[gi] = mode_reg;
      assign ovf_q[gi]  = ovf_reg;

`ifdef PERF_SNAPSHOT_EN
      // The shadow register captures the value from before this cycle's update.
      logic [CNTR_WIDTH-1:0] snap_reg;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          snap_reg <= '0;
        end else if (snap_wr) begin
          snap_reg <= cnt_reg;
        end
      end

      assign view_q[gi] = snap_reg;
`else
      assign view_q[gi] = cnt_reg;
`endif
    end
  endgenerate

  // CTRL read value: modes packed low, unused upper bits read 0.
  logic [31:0] ctrl_rd;
  always_comb begin
    ctrl_rd = '0;
    for (int k = 0; k < NUM_CNTRS; k++) begin
      ctrl_rd[2*k +: 2] = mode_q[k];
    end
  end

  // Read mux. Every input is a pre-update register value, so a counter read
  // returns the value from before this cycle's increment or preset.
  logic [31:0] rdata_next;
  always_comb begin
    rdata_next = '0;
    if (addr_word == 32'h00) begin
      rdata_next = ctrl_rd;
    end else if (addr_word == 32'h04) begin
      rdata_next = 32'(ovf_q);
    end
    for (int k = 0; k < NUM_CNTRS; k++) begin
      if (addr_word == 32'h40 + 32'(8 * k)) begin
        rdata_next = 32'(view_q[k][CNTR_WIDTH-1:32]);
      end else if (addr_word == 32'h44 + 32'(8 * k)) begin
        rdata_next = view_q[k][31:0];
      end
    end
  end

  logic [31:0] rdata_reg;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_reg <= '0;
    end else begin
      rdata_reg <= rdata_next;
    end
  end

  assign rdata_o    = rdata_reg;
  assign overflow_o = ovf_q;

  // Event bit 0 has no consumer. SNAP is also unused when the snapshot
  // feature is not built.
  logic unused_sig;
  assign unused_sig = ^{event_i[0], snap_wr};

endmodule
